// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_RISE,
    HIGH,
    LOW
  } pwm_capture_state_e;

  localparam int unsigned MinSyncStages = 2;

endpackage

// File: rtl/pwm_capture_sync.sv
// Synchroniser chain for the asynchronous PWM input, with edge detection.
module pwm_capture_sync
  import pwm_capture_pkg::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pwm,
  output logic o_pwm_sync,
  output logic o_rise_c,
  output logic o_fall_c
);

  // Chains shorter than two flops are not metastability-safe; clamp them.
  localparam int unsigned Stages = (SyncStages < MinSyncStages) ? MinSyncStages : SyncStages;

  logic [Stages-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[Stages-2:0], i_pwm};
      r_prev <= r_sync[Stages-1];
    end
  end

  assign o_pwm_sync = r_sync[Stages-1];
  assign o_rise_c   = r_sync[Stages-1] & ~r_prev;
  assign o_fall_c   = ~r_sync[Stages-1] & r_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an external PWM waveform in clock cycles
// and publishes each completed measurement with a one-cycle valid strobe.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CounterSize = 16,
  parameter int unsigned SyncStages  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   pwm_i,
  output logic [CounterSize-1:0] period_o,
  output logic [CounterSize-1:0] high_time_o,
  output logic                   overflow_o,
  output logic                   valid_o
);

  localparam logic [CounterSize-1:0] CntMax = {CounterSize{1'b1}};

  pwm_capture_state_e r_state;
  pwm_capture_state_e w_state_next;

  logic                   w_pwm_sync;
  logic                   w_rise_c;
  logic                   w_fall_c;
  logic [CounterSize-1:0] r_cnt;
  logic [CounterSize-1:0] r_high_cnt;
  logic [CounterSize-1:0] r_period;
  logic [CounterSize-1:0] r_high_time;
  logic                   r_overflow;
  logic                   r_valid;

  logic w_cnt_clr;
  logic w_cnt_load;
  logic w_cnt_inc;
  logic w_high_latch;
  logic w_publish;
  logic w_saturate;

  pwm_capture_sync #(
    .SyncStages(SyncStages)
  ) u_sync (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_pwm     (pwm_i),
    .o_pwm_sync(w_pwm_sync),
    .o_rise_c  (w_rise_c),
    .o_fall_c  (w_fall_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and datapath controls; disable overrides every edge and saturation.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_inc    = 1'b0;
    w_high_latch = 1'b0;
    w_publish    = 1'b0;
    w_saturate   = 1'b0;
    if (!enable_i) begin
      w_state_next = IDLE;
      w_cnt_clr    = (r_state == IDLE);
    end else begin
      unique case (r_state)
        IDLE: begin
          w_cnt_clr    = 1'b1;
          w_state_next = ARM;
        end
        ARM: begin
          if (!w_pwm_sync) w_state_next = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (w_rise_c) begin
            w_cnt_load   = 1'b1;
            w_state_next = HIGH;
          end
        end
        HIGH: begin
          if (w_fall_c) begin
            w_high_latch = 1'b1;
            w_cnt_inc    = 1'b1;
            w_state_next = LOW;
          end else if (r_cnt == CntMax) begin
            w_saturate   = 1'b1;
            w_state_next = ARM;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        LOW: begin
          if (w_rise_c) begin
            w_publish    = 1'b1;
            w_cnt_load   = 1'b1;
            w_state_next = HIGH;
          end else if (r_cnt == CntMax) begin
            w_saturate   = 1'b1;
            w_state_next = ARM;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt       <= '0;
      r_high_cnt  <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_overflow  <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= w_publish | w_saturate;
      if (w_cnt_clr)                          r_cnt <= '0;
      else if (w_cnt_load)                    r_cnt <= CounterSize'(1);
      else if (w_cnt_inc && r_cnt != CntMax)  r_cnt <= r_cnt + CounterSize'(1);
      if (w_high_latch) r_high_cnt <= r_cnt;
      if (w_publish) begin
        r_period    <= r_cnt;
        r_high_time <= r_high_cnt;
        r_overflow  <= 1'b0;
      end else if (w_saturate) begin
        r_period    <= CntMax;
        r_high_time <= (r_state == HIGH) ? CntMax : r_high_cnt;
        r_overflow  <= 1'b1;
      end
    end
  end

  assign period_o    = r_period;
  assign high_time_o = r_high_time;
  assign overflow_o  = r_overflow;
  assign valid_o     = r_valid;

endmodule
